// File: rtl/ei_axi4_slave_mem_if.sv
// ei_axi4_slave_mem_if -- AXI4 bus bundle between a master (VIP/bench) and
// the ei_axi4_slave_mem responder. Clock and reset are plain module ports.
interface ei_axi4_slave_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  localparam int BYTES = DATA_WIDTH / 8;

  // write address channel
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  // write data channel
  logic [DATA_WIDTH-1:0] wdata;
  logic [BYTES-1:0]      wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  // write response channel
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  // read address channel
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  // read data channel
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/ei_axi4_slave_mem.sv
// ei_axi4_slave_mem -- synthesisable AXI4 slave memory. One write burst and
// one read burst in flight concurrently; FIXED/INCR/WRAP bursts, byte strobes,
// IDs echoed on B and R. All outputs are registered.
// Optional feature macro EI_AXI4_SLVERR_EN: out-of-range beats, reserved burst
// type and wlast misplacement report SLVERR; without it, addresses wrap modulo
// MEM_DEPTH and responses are always OKAY.
module ei_axi4_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input logic                aclk,
  input logic                areset,
  ei_axi4_slave_mem_if.slave s
);
  localparam int       BYTES    = DATA_WIDTH / 8;
  localparam int       OFF      = $clog2(BYTES);
  localparam int       IDXW     = $clog2(MEM_DEPTH);
  localparam int       HI_SHIFT = OFF + IDXW;
  localparam bit [2:0] SIZE_MAX = 3'(OFF);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // ---------------------------------------------------------------- helpers
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    if (size > SIZE_MAX) begin
      return SIZE_MAX;
    end else begin
      return size;
    end
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDXW'(addr >> OFF);
  endfunction

`ifdef EI_AXI4_SLVERR_EN
  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> HI_SHIFT) != {ADDR_WIDTH{1'b0}};
  endfunction
`endif

  // Address of the beat following addr. WRAP only wraps for legal lengths.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wmask;
    logic                  wrap_ok;
    incr    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
    wmask   = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (burst)
      2'b00:   return addr;
      2'b10: begin
        if (wrap_ok) begin
          return (addr & ~wmask) | ((addr + incr) & wmask);
        end else begin
          return addr + incr;
        end
      end
      default: return addr + incr;
    endcase
  endfunction

  // ---------------------------------------------------------------- storage
  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  // ---------------------------------------------------------------- write side
  w_state_t              w_state_r, w_state_nxt_s;
  logic                  awready_r, wready_r, bvalid_r;
  logic [ID_WIDTH-1:0]   bid_r;
  logic [1:0]            bresp_r;
  logic [ADDR_WIDTH-1:0] w_addr_r;
  logic [7:0]            aw_len_r;
  logic [2:0]            aw_size_r;
  logic [1:0]            aw_burst_r;
  logic [7:0]            w_cnt_r;
  logic                  w_err_r;
  logic                  aw_hs_s, w_hs_s, b_hs_s, w_last_beat_s;
  logic                  aw_err_s, w_beat_err_s, w_en_s;
  logic [IDXW-1:0]       w_idx_s;

  assign aw_hs_s       = s.awvalid & awready_r;
  assign w_hs_s        = s.wvalid & wready_r;
  assign b_hs_s        = bvalid_r & s.bready;
  assign w_last_beat_s = (w_cnt_r == aw_len_r);
  assign w_idx_s       = word_idx(w_addr_r);

`ifdef EI_AXI4_SLVERR_EN
  logic w_oor_s;
  assign w_oor_s      = addr_oor(w_addr_r);
  assign aw_err_s     = (s.awburst == 2'b11);
  assign w_beat_err_s = w_oor_s | (s.wlast != w_last_beat_s);
  assign w_en_s       = ~w_oor_s;
`else
  logic unused_s;
  assign unused_s     = s.wlast;
  assign aw_err_s     = 1'b0;
  assign w_beat_err_s = 1'b0;
  assign w_en_s       = 1'b1;
`endif

  assign s.awready = awready_r;
  assign s.wready  = wready_r;
  assign s.bvalid  = bvalid_r;
  assign s.bid     = bid_r;
  assign s.bresp   = bresp_r;

  // Write FSM next-state decode.
  always_comb begin
    w_state_nxt_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s) begin
          w_state_nxt_s = W_DATA;
        end else begin
          w_state_nxt_s = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_hs_s && w_last_beat_s) begin
          w_state_nxt_s = W_RESP;
        end else begin
          w_state_nxt_s = W_DATA;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          w_state_nxt_s = W_IDLE;
        end else begin
          w_state_nxt_s = W_RESP;
        end
      end
      default: w_state_nxt_s = W_IDLE;
    endcase
  end

  // Write FSM state and registered handshake outputs derived from next state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_state_nxt_s;
      awready_r <= (w_state_nxt_s == W_IDLE);
      wready_r  <= (w_state_nxt_s == W_DATA);
      bvalid_r  <= (w_state_nxt_s == W_RESP);
    end
  end

  // Write burst context: latch AW fields, step address and beat count, build B.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bid_r      <= {ID_WIDTH{1'b0}};
      bresp_r    <= 2'b00;
      w_addr_r   <= {ADDR_WIDTH{1'b0}};
      aw_len_r   <= 8'd0;
      aw_size_r  <= 3'd0;
      aw_burst_r <= 2'b00;
      w_cnt_r    <= 8'd0;
      w_err_r    <= 1'b0;
    end else if (aw_hs_s) begin
      bid_r      <= s.awid;
      w_addr_r   <= s.awaddr;
      aw_len_r   <= s.awlen;
      aw_size_r  <= clamp_size(s.awsize);
      aw_burst_r <= s.awburst;
      w_cnt_r    <= 8'd0;
      w_err_r    <= aw_err_s;
    end else if (w_hs_s) begin
      w_addr_r <= next_addr(w_addr_r, aw_len_r, aw_size_r, aw_burst_r);
      w_cnt_r  <= w_cnt_r + 8'd1;
      w_err_r  <= w_err_r | w_beat_err_s;
      if (w_last_beat_s) begin
        bresp_r <= (w_err_r | w_beat_err_s) ? 2'b10 : 2'b00;
      end
    end
  end

  // Memory array write port with per-byte enables; contents survive reset.
  always_ff @(posedge aclk) begin
    if (w_hs_s && w_en_s && !areset) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s.wstrb[b]) begin
          mem_r[w_idx_s][8*b +: 8] <= s.wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------- read side
  r_state_t              r_state_r, r_state_nxt_s;
  logic                  arready_r, rvalid_r, rlast_r;
  logic [ID_WIDTH-1:0]   rid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [1:0]            rresp_r;
  logic [ADDR_WIDTH-1:0] r_addr_r;
  logic [7:0]            r_len_r;
  logic [2:0]            r_size_r;
  logic [1:0]            r_burst_r;
  logic [7:0]            r_cnt_r;
  logic                  ar_hs_s, r_hs_s;
  logic [ADDR_WIDTH-1:0] r_ld_addr_s;
  logic [7:0]            r_ld_len_s;
  logic [2:0]            r_ld_size_s;
  logic [1:0]            r_ld_burst_s;
  logic [IDXW-1:0]       r_idx_s;
  logic [DATA_WIDTH-1:0] r_word_s, r_beat_data_s;
  logic                  r_beat_err_s;

  assign ar_hs_s  = s.arvalid & arready_r;
  assign r_hs_s   = rvalid_r & s.rready;
  assign r_idx_s  = word_idx(r_ld_addr_s);
  assign r_word_s = mem_r[r_idx_s];

`ifdef EI_AXI4_SLVERR_EN
  logic r_oor_s;
  assign r_oor_s       = addr_oor(r_ld_addr_s);
  assign r_beat_err_s  = r_oor_s | (r_ld_burst_s == 2'b11);
  assign r_beat_data_s = r_oor_s ? {DATA_WIDTH{1'b0}} : r_word_s;
`else
  assign r_beat_err_s  = 1'b0;
  assign r_beat_data_s = r_word_s;
`endif

  assign s.arready = arready_r;
  assign s.rvalid  = rvalid_r;
  assign s.rlast   = rlast_r;
  assign s.rid     = rid_r;
  assign s.rdata   = rdata_r;
  assign s.rresp   = rresp_r;

  // Select which beat to load: beat 0 straight from AR, later beats from context.
  always_comb begin
    r_ld_addr_s  = r_addr_r;
    r_ld_len_s   = r_len_r;
    r_ld_size_s  = r_size_r;
    r_ld_burst_s = r_burst_r;
    if (ar_hs_s) begin
      r_ld_addr_s  = s.araddr;
      r_ld_len_s   = s.arlen;
      r_ld_size_s  = clamp_size(s.arsize);
      r_ld_burst_s = s.arburst;
    end else begin
      r_ld_addr_s  = r_addr_r;
      r_ld_len_s   = r_len_r;
      r_ld_size_s  = r_size_r;
      r_ld_burst_s = r_burst_r;
    end
  end

  // Read FSM next-state decode.
  always_comb begin
    r_state_nxt_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_nxt_s = R_DATA;
        end else begin
          r_state_nxt_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (r_hs_s && rlast_r) begin
          r_state_nxt_s = R_IDLE;
        end else begin
          r_state_nxt_s = R_DATA;
        end
      end
      default: r_state_nxt_s = R_IDLE;
    endcase
  end

  // Read FSM state and registered handshake outputs derived from next state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      r_state_r <= r_state_nxt_s;
      arready_r <= (r_state_nxt_s == R_IDLE);
      rvalid_r  <= (r_state_nxt_s == R_DATA);
    end
  end

  // Read burst context and R channel registers; held while rready is low.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rid_r     <= {ID_WIDTH{1'b0}};
      rdata_r   <= {DATA_WIDTH{1'b0}};
      rresp_r   <= 2'b00;
      rlast_r   <= 1'b0;
      r_addr_r  <= {ADDR_WIDTH{1'b0}};
      r_len_r   <= 8'd0;
      r_size_r  <= 3'd0;
      r_burst_r <= 2'b00;
      r_cnt_r   <= 8'd0;
    end else if (ar_hs_s) begin
      rid_r     <= s.arid;
      r_len_r   <= r_ld_len_s;
      r_size_r  <= r_ld_size_s;
      r_burst_r <= r_ld_burst_s;
      r_cnt_r   <= 8'd0;
      rlast_r   <= (r_ld_len_s == 8'd0);
      rdata_r   <= r_beat_data_s;
      rresp_r   <= r_beat_err_s ? 2'b10 : 2'b00;
      r_addr_r  <= next_addr(r_ld_addr_s, r_ld_len_s, r_ld_size_s, r_ld_burst_s);
    end else if (r_hs_s && !rlast_r) begin
      r_cnt_r  <= r_cnt_r + 8'd1;
      rlast_r  <= ((r_cnt_r + 8'd1) == r_len_r);
      rdata_r  <= r_beat_data_s;
      rresp_r  <= r_beat_err_s ? 2'b10 : 2'b00;
      r_addr_r <= next_addr(r_ld_addr_s, r_ld_len_s, r_ld_size_s, r_ld_burst_s);
    end else if (r_hs_s) begin
      rlast_r <= 1'b0;
    end
  end
endmodule

// File: doc/ei_axi4_slave_mem.md
# ei_axi4_slave_mem

Synthesisable AXI4 slave memory model with parametrised data/address/ID width and depth. It is the RTL-side counterpart of the VIP's slave driver and sits behind the AXI4 interface as the DUT-side responder in bench topologies. It serves one write burst and one read burst concurrently, supporting FIXED, INCR and WRAP bursts, byte strobes and transaction IDs echoed on the response channels.

## Interface

- DATA_WIDTH, 32: data bus width in bits; 8·2^n, max 1024; BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte address width.
- ID_WIDTH, 4: AXI ID width, ≥1.
- MEM_DEPTH, 1024: number of DATA_WIDTH words; power of two.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- awid / awaddr  in  ID_WIDTH / ADDR_WIDTH  write burst ID, start byte address.
- awlen / awsize / awburst  in  8 / 3 / 2  beats-1, log2 bytes per beat, burst type.
- awvalid in 1, awready out 1  AW handshake.
- wdata / wstrb / wlast  in  DATA_WIDTH / BYTES / 1  write beat data, byte enables, last flag.
- wvalid in 1, wready out 1  W handshake.
- bid / bresp  out  ID_WIDTH / 2  write response ID, response.
- bvalid out 1, bready in 1  B handshake.
- arid / araddr  in  ID_WIDTH / ADDR_WIDTH  read burst ID, start byte address.
- arlen / arsize / arburst  in  8 / 3 / 2  as for AW.
- arvalid in 1, arready out 1  AR handshake.
- rid / rdata / rresp / rlast  out  ID_WIDTH / DATA_WIDTH / 2 / 1  read beat ID, data, response, last flag.
- rvalid out 1, rready in 1  R handshake.

## Operation

- Write FSM W_IDLE → W_DATA → W_RESP. W_IDLE: awready=1; on AW handshake latch id/addr/len/size/burst and go to W_DATA. W_DATA: wready=1; each W handshake writes the bytes where wstrb=1 and advances the address; after beat awlen+1, go to W_RESP. W_RESP: bvalid=1 with latched bid; on bready go to W_IDLE.
- Read FSM R_IDLE → R_DATA. R_IDLE: arready=1; on AR handshake latch fields and load beat 0 into the rdata register. R_DATA: rvalid=1; each R handshake loads the next beat; rlast=1 on beat arlen+1. R handshake on the last beat returns to R_IDLE.
- Beat address: FIXED holds the start address. INCR adds 2^size. WRAP adds 2^size within a window of (len+1)·2^size bytes aligned to that size; WRAP with len not in {1,3,7,15} behaves as INCR.
- Word index = addr[ADDR_WIDTH-1 : log2(BYTES)]. A size > log2(BYTES) is clamped to log2(BYTES).
- The beat count comes from the latched len, not from wlast. wlast is only checked.
- The same word written and read on the same edge returns the old data.
- Memory contents are not cleared by reset.

## Timing

- Reset values: awready, wready, bvalid, arready, rvalid and rlast are 0; bid, bresp, rid, rdata and rresp are 0. awready and arready rise in the first cycle after areset deasserts.
- AW handshake at edge N: wready=1 from N+1. Last W handshake at edge M: bvalid=1 from M+1, held until bready.
- AR handshake at edge N: rvalid=1 with beat 0 from N+1. Back-to-back beats are accepted every cycle while rready=1. rvalid, rdata and rlast are held stable while rready=0.
- Minimum turnaround: the next AW or AR is accepted the cycle after the B or last-R handshake.
- areset asserted mid-burst aborts both FSMs to IDLE; no B or R is issued. Beats already written remain in memory.

## Configuration

- EI_AXI4_SLVERR_EN defined:
  - A beat with word index ≥ MEM_DEPTH is not written and, on reads, returns rdata=0, rresp=2'b10.
  - bresp=2'b10 if any beat of the write was out of range, if awburst=2'b11, or if wlast differed from the counted final beat.
  - A read with arburst=2'b11 returns 2'b10 on every beat.
- Undefined: index is taken modulo MEM_DEPTH; bresp and rresp are always 2'b00; wlast is ignored.

## Test plan

- INCR write awaddr=0x10, awlen=3, awsize=2, awid=5, data 0xA0..0xA3, wstrb=0xF; then read back with arid=9 → bid=5, bresp=0; four R beats 0xA0..0xA3 with rid=9, rlast only on beat 4.
- WRAP read araddr=0x38, arlen=3, arsize=2 → beat addresses 0x38, 0x3C, 0x30, 0x34.
- Write wstrb=0x3 with wdata=0xFFFFFFFF over a word holding 0x12345678 → read returns 0x1234FFFF.
- rready held low 5 cycles mid-burst while a write runs concurrently → rdata stable and no beat lost; B completes independently.
- With EI_AXI4_SLVERR_EN: write awaddr=MEM_DEPTH·BYTES → bresp=2'b10, memory unchanged. Without the macro, the same write lands at word 0.
- areset pulsed after beat 2 of a 4-beat write → no bvalid; awready=1 the cycle after release; words 0–1 updated, words 2–3 unchanged.
